aload_seq: RTL and testbench
============================

ALOAD_SEQ -- requirements
Module: aload_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, async-load bank width in bits.
REQ-002 SHALL have parameter SETUP_CYC, default 1, cycles bank_rval stable before load (legal 1..15).
REQ-003 SHALL have parameter PULSE_CYC, default 2, cycles bank_aload held high (legal 1..15).
REQ-004 SHALL have parameter RECOV_CYC, default 1, cycles after load before capture re-enabled (legal 1..15).
REQ-005 SHALL have clock and reset: one clock; reset is asynchronous and active-high, ports named clk and arst.
REQ-006 SHALL have ports: clk in 1 clock; arst in 1 async active-high reset.
REQ-007 SHALL have ports: req in 2 load requests, bit i = requester i; val0 in WIDTH value of requester 0; val1 in WIDTH value of requester 1.
REQ-008 SHALL have ports: gnt out 2 one-cycle completion pulse per requester; busy out 1 sequence in progress.
REQ-009 SHALL have ports: bank_aload out 1 async-load strobe to bank; bank_rval out WIDTH load value to bank; bank_cen out 1 normal-capture enable to bank.
REQ-010 SHALL have ports (ALOAD_SEQ_CHECK_EN only): bank_q in WIDTH bank outputs; err out 1 sticky readback mismatch.

Function
REQ-011 SHALL implement FSM IDLE, SETUP, LOAD, RECOV, DONE with one 4-bit down-counter.
REQ-012 IDLE: if req nonzero at edge, SHALL select winner, latch its val into bank_rval, load counter with SETUP_CYC, go SETUP; else stay.
REQ-013 Arbitration SHALL be round-robin: single request wins; both set -> requester other than last winner wins; last-winner pointer resets to 1 so req0 wins the first tie.
REQ-014 SETUP SHALL hold bank_aload=0 for SETUP_CYC cycles, then go LOAD with counter=PULSE_CYC.
REQ-015 LOAD SHALL drive bank_aload=1 for exactly PULSE_CYC cycles, then go RECOV with counter=RECOV_CYC.
REQ-016 RECOV SHALL hold bank_aload=0 for RECOV_CYC cycles, then go DONE.
REQ-017 DONE SHALL assert gnt[winner] for exactly one cycle, then return IDLE; gnt SHALL be one-hot or zero.
REQ-018 bank_cen SHALL be 0 in SETUP, LOAD, RECOV, DONE and 1 in IDLE; busy SHALL be 1 whenever state is not IDLE.
REQ-019 bank_rval SHALL remain constant from accept edge until next accept; val inputs ignored outside IDLE.
REQ-020 Latency: accept at edge t -> bank_aload high from edge t+SETUP_CYC to t+SETUP_CYC+PULSE_CYC; gnt high in cycle starting t+SETUP_CYC+PULSE_CYC+RECOV_CYC; next accept earliest one edge later.
REQ-021 Requester dropping req after acceptance SHALL NOT abort the sequence; gnt still issued.
REQ-022 Request held through its own gnt cycle SHALL be treated as new request in IDLE.
REQ-023 All outputs SHALL be registered; no combinational path from req/val to bank_* outputs.

Reset
REQ-024 arst asserted SHALL immediately, independent of clk, force IDLE, counter 0, bank_aload=0, bank_rval=0, bank_cen=1, gnt=0, busy=0, err=0, pointer=1.
REQ-025 arst mid-sequence (including during LOAD) SHALL abort with no gnt issued; bank_aload deasserts asynchronously.
REQ-026 First accept SHALL occur no earlier than the first clk edge after arst deasserts.

Configuration
REQ-027 Macro ALOAD_SEQ_CHECK_EN defined: bank_q and err ports SHALL exist; in DONE bank_q SHALL be compared to bank_rval and err set on mismatch, cleared only by arst.
REQ-028 Macro ALOAD_SEQ_CHECK_EN undefined: bank_q and err ports SHALL be absent; all other behaviour identical.

Verification
REQ-029 Defaults, req=01, val0=0xA5 at edge 0 -> bank_rval=0xA5 from edge 0, bank_aload high edges 1-3, gnt=01 in cycle 4, busy=0 at edge 5.
REQ-030 req=11 held from reset -> gnt order 01, 10, 01, 10; each sequence 5 cycles edge-to-edge.
REQ-031 req0 pulsed one cycle, val0 changed to 0x00 at edge 1 -> full sequence completes, bank_rval stays 0xA5, gnt=01 issued.
REQ-032 arst asserted mid-LOAD (edge 2) -> bank_aload falls asynchronously, no gnt, bank_cen=1, bank_rval=0; new req accepted at first edge after release.
REQ-033 ALOAD_SEQ_CHECK_EN, bench model of bank forces bank_q=0x5A while loading 0xA5 -> err=1 after DONE, remains 1 through later correct loads until arst.
REQ-034 SETUP_CYC=3, PULSE_CYC=1, RECOV_CYC=4 -> bank_aload high exactly 1 cycle after 3 setup cycles, gnt 8 edges after accept.

Source files
------------

// File: rtl/aload_seq.sv
`default_nettype none
// ============================================================================
// Module   : aload_seq
// Purpose  : Sequences an asynchronous-load operation into a register bank on
//            behalf of two requesters. A round-robin winner's value is
//            presented on bank_rval and held through a setup window. The
//            bank_aload strobe is then pulsed, followed by a recovery window,
//            before the winner gets a one-cycle completion grant.
//            bank_cen enables normal capture only while idle.
// Ports    : clk, arst      - clock, asynchronous active-high reset
//            req[1:0]       - load requests, bit i = requester i
//            val0, val1     - load values of requester 0 / 1
//            gnt[1:0]       - one-cycle completion pulse per requester
//            busy           - sequence in progress
//            bank_aload     - async-load strobe to bank
//            bank_rval      - load value to bank
//            bank_cen       - normal-capture enable to bank
//            bank_q, err    - bank readback and sticky mismatch flag
//                             (present only with ALOAD_SEQ_CHECK_EN defined)
// Options  : `define ALOAD_SEQ_CHECK_EN enables the readback check.
// Revision : 1.0 - initial release
// ============================================================================
module aload_seq #(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int RECOV_CYC = 1
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] val0,
   input  logic [WIDTH-1:0] val1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             bank_aload,
   output logic [WIDTH-1:0] bank_rval,
   output logic             bank_cen
`ifdef ALOAD_SEQ_CHECK_EN
   ,
   input  logic [WIDTH-1:0] bank_q,
   output logic             err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_LOAD  = 3'd2,
      S_RECOV = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] C_SETUP = 4'(SETUP_CYC);
   localparam logic [3:0] C_PULSE = 4'(PULSE_CYC);
   localparam logic [3:0] C_RECOV = 4'(RECOV_CYC);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   // Last winner; doubles as the round-robin pointer (reset 1 so req0 wins
   // the first tie).
   logic             win_q, win_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             busy_q, busy_d;
   logic             aload_q, aload_d;
   logic [WIDTH-1:0] rval_q, rval_d;
   logic             cen_q, cen_d;
`ifdef ALOAD_SEQ_CHECK_EN
   logic             err_q, err_d;
`endif

   logic             pick;

   always_comb begin
      pick    = (req == 2'b11) ? ~win_q : req[1];

      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      gnt_d   = 2'b00;
      aload_d = aload_q;
      rval_d  = rval_q;
`ifdef ALOAD_SEQ_CHECK_EN
      err_d   = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_d = S_SETUP;
               cnt_d   = C_SETUP;
               win_d   = pick;
               rval_d  = pick ? val1 : val0;
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd1) begin
               state_d = S_LOAD;
               cnt_d   = C_PULSE;
               aload_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_LOAD: begin
            if (cnt_q == 4'd1) begin
               state_d = S_RECOV;
               cnt_d   = C_RECOV;
               aload_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RECOV: begin
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
               gnt_d   = win_q ? 2'b10 : 2'b01;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
`ifdef ALOAD_SEQ_CHECK_EN
            if (bank_q != rval_q) begin
               err_d = 1'b1;
            end
`endif
            // Accepting straight from DONE lets back-to-back requests run
            // with no idle gap between sequences.
            if (req != 2'b00) begin
               state_d = S_SETUP;
               cnt_d   = C_SETUP;
               win_d   = pick;
               rval_d  = pick ? val1 : val0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            aload_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      cen_d  = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         win_q   <= 1'b1;
         gnt_q   <= 2'b00;
         busy_q  <= 1'b0;
         aload_q <= 1'b0;
         rval_q  <= '0;
         cen_q   <= 1'b1;
`ifdef ALOAD_SEQ_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         aload_q <= aload_d;
         rval_q  <= rval_d;
         cen_q   <= cen_d;
`ifdef ALOAD_SEQ_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign gnt        = gnt_q;
   assign busy       = busy_q;
   assign bank_aload = aload_q;
   assign bank_rval  = rval_q;
   assign bank_cen   = cen_q;
`ifdef ALOAD_SEQ_CHECK_EN
   assign err        = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aload_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aload_seq
// Purpose  : Self-checking bench for aload_seq. Two instances run side by
//            side (default timing and SETUP=3/PULSE=1/RECOV=4) on shared
//            stimulus, each compared every cycle against a transaction-level
//            reference model. Readback check exercised when
//            ALOAD_SEQ_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aload_seq;

   logic             clk = 1'b0;
   logic             arst;
   logic [1:0]       req;
   logic [7:0]       val0, val1;
   logic [1:0][1:0]  gnt_o;
   logic [1:0]       busy_o, aload_o, cen_o;
   logic [1:0][7:0]  rval_o;
`ifdef ALOAD_SEQ_CHECK_EN
   logic [1:0][7:0]  bank_q;
   logic [1:0]       err_o;
   bit               corrupt = 1'b0;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aload_seq dut0 (
      .clk(clk), .arst(arst), .req(req), .val0(val0), .val1(val1),
      .gnt(gnt_o[0]), .busy(busy_o[0]), .bank_aload(aload_o[0]),
      .bank_rval(rval_o[0]), .bank_cen(cen_o[0])
`ifdef ALOAD_SEQ_CHECK_EN
      , .bank_q(bank_q[0]), .err(err_o[0])
`endif
   );

   aload_seq #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .RECOV_CYC(4)) dut1 (
      .clk(clk), .arst(arst), .req(req), .val0(val0), .val1(val1),
      .gnt(gnt_o[1]), .busy(busy_o[1]), .bank_aload(aload_o[1]),
      .bank_rval(rval_o[1]), .bank_cen(cen_o[1])
`ifdef ALOAD_SEQ_CHECK_EN
      , .bank_q(bank_q[1]), .err(err_o[1])
`endif
   );

   // ---------------- reference model ----------------
   // Each sequence is tracked as "k cycles since accept": aload is high for
   // k in [S, S+P), gnt at k == S+P+R, and the next accept may happen one
   // edge after that.
   function automatic int ps(int i); return (i == 0) ? 1 : 3; endfunction
   function automatic int pp(int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int pr(int i); return (i == 0) ? 1 : 4; endfunction
   function automatic int tot(int i); return ps(i) + pp(i) + pr(i); endfunction

   bit         m_act[2];
   int         m_k[2];
   bit         m_win[2];
   logic [7:0] m_rval[2];
   bit         m_err[2];

   function automatic bit e_aload(int i);
      return m_act[i] && (m_k[i] >= ps(i)) && (m_k[i] < ps(i) + pp(i));
   endfunction

   function automatic logic [1:0] e_gnt(int i);
      if (m_act[i] && m_k[i] == tot(i)) return m_win[i] ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i]  = 1'b0;
         m_k[i]    = 0;
         m_win[i]  = 1'b1;
         m_rval[i] = 8'h00;
         m_err[i]  = 1'b0;
      end
   endfunction

   function automatic void model_edge(int i);
      if (m_act[i]) m_k[i]++;
      if (m_act[i] && m_k[i] > tot(i)) begin
`ifdef ALOAD_SEQ_CHECK_EN
         if (bank_q[i] != m_rval[i]) m_err[i] = 1'b1;
`endif
         m_act[i] = 1'b0;
      end
      if (!m_act[i] && req != 2'b00) begin
         m_win[i]  = (req == 2'b11) ? !m_win[i] : req[1];
         m_rval[i] = m_win[i] ? val1 : val0;
         m_act[i]  = 1'b1;
         m_k[i]    = 0;
      end
   endfunction

`ifdef ALOAD_SEQ_CHECK_EN
   // Bank model: captures the value presented while the strobe is high;
   // instance 0 can be made to capture a wrong value for 0xA5.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (e_aload(i))
            bank_q[i] = (i == 0 && corrupt && m_rval[i] == 8'hA5) ? 8'h5A : m_rval[i];
      end
   end
`endif

   // ---------------- checking helpers ----------------
   function automatic void chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", name, idx, $time, act, exp);
      end
   endfunction

   task automatic check_all(string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, ".gnt"},   i, 32'(gnt_o[i]),   32'(e_gnt(i)));
         chk({tag, ".busy"},  i, 32'(busy_o[i]),  32'(m_act[i]));
         chk({tag, ".aload"}, i, 32'(aload_o[i]), 32'(e_aload(i)));
         chk({tag, ".cen"},   i, 32'(cen_o[i]),   32'(!m_act[i]));
         chk({tag, ".rval"},  i, 32'(rval_o[i]),  32'(m_rval[i]));
`ifdef ALOAD_SEQ_CHECK_EN
         chk({tag, ".err"},   i, 32'(err_o[i]),   32'(m_err[i]));
`endif
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(string tag);
      arst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1 arst = 1'b0;
   endtask

   task automatic idle_steps(int n, string tag);
      req = 2'b00;
      for (int j = 0; j < n; j++) step(tag);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0] req;
      logic [7:0] v0;
      logic [1:0] gnt;
      logic       busy;
      logic       aload;
      logic       cen;
      logic [7:0] rval;
   } vec_t;

   vec_t tbl[6];

   initial begin
      // Default timing, single request pulsed at edge 0 with val0 dropping
      // to 0x00 afterwards: value must be held, grant still issued.
      tbl[0] = '{2'b01, 8'hA5, 2'b00, 1'b1, 1'b0, 1'b0, 8'hA5};
      tbl[1] = '{2'b00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 8'hA5};
      tbl[2] = '{2'b00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 8'hA5};
      tbl[3] = '{2'b00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 8'hA5};
      tbl[4] = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 8'hA5};
      tbl[5] = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5};

      arst = 1'b0;
      req  = 2'b00;
      val0 = 8'h00;
      val1 = 8'h00;
      #1;
      do_reset("reset");

      for (int i = 0; i < 6; i++) begin
         req  = tbl[i].req;
         val0 = tbl[i].v0;
         step("tbl");
         chk("tbl_gnt",   i, 32'(gnt_o[0]),   32'(tbl[i].gnt));
         chk("tbl_busy",  i, 32'(busy_o[0]),  32'(tbl[i].busy));
         chk("tbl_aload", i, 32'(aload_o[0]), 32'(tbl[i].aload));
         chk("tbl_cen",   i, 32'(cen_o[0]),   32'(tbl[i].cen));
         chk("tbl_rval",  i, 32'(rval_o[0]),  32'(tbl[i].rval));
      end
      idle_steps(6, "tbl_tail");

      // Both requesting continuously: alternating grants every 5 edges.
      do_reset("rr_reset");
      req  = 2'b11;
      val0 = 8'h11;
      val1 = 8'h22;
      for (int j = 0; j < 20; j++) begin
         step("rr");
         chk("rr_gnt", j, 32'(gnt_o[0]),
             32'((j % 5 != 4) ? 2'b00 : (((j / 5) % 2 == 1) ? 2'b10 : 2'b01)));
      end
      idle_steps(10, "rr_tail");

      // Reset in the middle of the load pulse.
      do_reset("mid_reset");
      req  = 2'b01;
      val0 = 8'hA5;
      step("mid");
      req = 2'b00;
      step("mid");
      step("mid");
      chk("mid_aload_hi", 0, 32'(aload_o[0]), 32'd1);
      do_reset("mid_abort");
      chk("abort_aload", 0, 32'(aload_o[0]), 32'd0);
      chk("abort_cen",   0, 32'(cen_o[0]),   32'd1);
      chk("abort_rval",  0, 32'(rval_o[0]),  32'd0);
      chk("abort_gnt",   0, 32'(gnt_o[0]),   32'd0);
      req  = 2'b10;
      val1 = 8'h77;
      step("post_rst");
      chk("post_rst_busy", 0, 32'(busy_o[0]), 32'd1);
      chk("post_rst_rval", 0, 32'(rval_o[0]), 32'h77);
      idle_steps(10, "post_rst_tail");

      // Alternate timing on instance 1: 3 setup, 1 pulse, grant 8 edges on.
      do_reset("alt_reset");
      req  = 2'b01;
      val0 = 8'h3C;
      for (int k = 0; k < 10; k++) begin
         step("alt");
         req = 2'b00;
         chk("alt_aload", k, 32'(aload_o[1]), 32'(k == 3));
         chk("alt_gnt",   k, 32'(gnt_o[1]),   32'((k == 8) ? 2'b01 : 2'b00));
      end

`ifdef ALOAD_SEQ_CHECK_EN
      // Faulty bank readback sets a sticky error that survives good loads.
      do_reset("err_reset");
      corrupt = 1'b1;
      req  = 2'b01;
      val0 = 8'hA5;
      step("err");
      idle_steps(6, "err");
      chk("err_set", 0, 32'(err_o[0]), 32'd1);
      corrupt = 1'b0;
      req  = 2'b01;
      step("err2");
      idle_steps(10, "err2");
      chk("err_sticky", 0, 32'(err_o[0]), 32'd1);
      do_reset("err_clr");
      chk("err_clr", 0, 32'(err_o[0]), 32'd0);
`endif

      // Randomised traffic with occasional asynchronous resets.
      for (int n = 0; n < 400; n++) begin
         int r;
         r    = $urandom_range(0, 9);
         req  = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
         val0 = 8'($urandom);
         val1 = 8'($urandom);
`ifdef ALOAD_SEQ_CHECK_EN
         corrupt = ($urandom_range(0, 19) == 0);
`endif
         step("rnd");
         if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
